regfile_port_ctrl: RTL
======================

# regfile_port_ctrl

Initiator-side controller for the CPU register file. It accepts write requests from writeback and operand-read requests from decode, each on its own valid/ready channel. It serializes them onto the register file's single shared port, where each enabled cycle is either a read or a write, and read data is registered. It buffers read results and clears the register file while reset is held.

## Interface
- STARVE_LIMIT, 4: consecutive cycles a pending read may lose to writes before it is forced to win.
- clk  in  1  Single clock; all state updates on posedge.
- reset  in  1  Synchronous, active-high reset.
- wr_valid / wr_ready  in / out  1 / 1  Write channel handshake.
- wr_rd  in  5  Destination register.
- wr_data  in  32  Write data.
- rd_valid / rd_ready  in / out  1 / 1  Read channel handshake.
- rd_rs1, rd_rs2  in  5 each  Source registers.
- rsp_valid / rsp_ready  out / in  1 / 1  Read-response handshake.
- rsp_data1, rsp_data2  out  32 each  Operand values.
- rf_enable, rf_rw, rf_reset  out  1 each  Register-file control. rf_rw=1 is a write.
- rf_rs1, rf_rs2, rf_rd  out  5 each  Register-file addresses.
- rf_din  out  32  Register-file write data.
- rf_out1, rf_out2  in  32 each  Register-file registered read outputs.

## Operation
- FSM states:
  - IDLE: a read may be issued.
  - RD_CAP: the cycle after a read issue. A write may be issued in this state; a read may not.
- Write grant (combinational):
  - Condition: wr_valid & !reset & !force_rd.
  - Drives wr_ready=1, rf_enable=1, rf_rw=1, rf_rd=wr_rd, rf_din=wr_data.
- Read grant (combinational):
  - Condition: rd_valid & !reset & state==IDLE & buf_free & (!wr_valid | force_rd).
  - buf_free is !rsp_valid | rsp_ready.
  - Drives rd_ready=1, rf_enable=1, rf_rw=0, rf_rs1/rf_rs2 from request. Next state is RD_CAP.
- RD_CAP:
  - At the end of the cycle, rf_out1/rf_out2 are loaded into the response buffer and rsp_valid is set.
  - Next state is IDLE.
- Response buffer:
  - One entry.
  - rsp_valid clears on rsp_valid & rsp_ready unless a capture occurs in the same cycle, in which case it stays set with the new data.
  - rsp_data holds stable while rsp_valid & !rsp_ready.
- Starvation counter (width clog2(STARVE_LIMIT+1)):
  - Increments, saturating, each cycle rd_valid is high but the read is blocked only by a write grant.
  - force_rd = (counter == STARVE_LIMIT).
  - Clears on read accept or when rd_valid is low.
- With no grant: rf_enable=0, rf_rw=0, and address/data outputs are 0.
- Reset clear: while reset=1, rf_enable=1 and rf_reset=1 so the register file zeroes on the same edge. Both handshake readies are 0.

## Timing
- Reset values: state IDLE, rsp_valid=0, rsp_data1/2=0, counter=0, wr_ready=0, rd_ready=0.
- Reset mid-operation: any in-flight read or buffered response is discarded.
- Write latency: the register is updated at the accept edge. A read issued the next cycle returns the new value.
- Read latency: accept at cycle N, rsp_valid=1 from cycle N+2.
- Read throughput: at most one read per 2 cycles. Writes can be accepted every cycle, including during RD_CAP.
- Simultaneous wr_valid & rd_valid in IDLE: the write wins unless force_rd. After a forced read, the counter resets.
- Same-register write and read requested in the same cycle: the write goes first, so the read returns the written value.
- rsp_ready low: rd_ready stays 0 until the buffer drains. Writes are unaffected.

## Configuration
- RF_ZERO_REG_EN defined (x0 hardwired to zero):
  - Writes with wr_rd==0 are accepted (wr_ready per normal grant) but rf_enable=0, so no register-file write occurs.
  - Reads substitute 0 for any operand whose source is register 0, at capture time.
- RF_ZERO_REG_EN undefined: register 0 is an ordinary register.

## Structure
- Package regfile_pkg holds:
  - XLEN=32 and REG_AW=5.
  - The state typedef (IDLE, RD_CAP).
  - The read-request and write-request typedefs.
- Sub-module rf_rsp_buf: the one-entry response buffer with valid/ready, load, and hold logic.

## Test plan
- Reset for 2 cycles, release -> rf_enable=1 and rf_reset=1 during reset; afterwards rsp_valid=0 and both readies follow grants.
- Write x5=0xDEADBEEF, then read rs1=5, rs2=0 with rsp_ready=1 -> rsp_data1=0xDEADBEEF and rsp_data2=0, rsp_valid exactly 2 cycles after read accept.
- wr_valid held high with continuous writes, rd_valid high, STARVE_LIMIT=4 -> read accepted on the 5th contended cycle and wr_ready=0 in that cycle.
- Same-cycle write x7=0x1234 and read rs1=7 -> write accepted first; response data1=0x1234.
- rsp_ready=0 with a response pending and a new read valid -> rd_ready=0 and rsp_data stable; raising rsp_ready lets the new read be accepted in that same cycle.
- With RF_ZERO_REG_EN, write x0=0xFFFF then read rs1=0 -> no rf write (rf_enable=0 in the accept cycle) and rsp_data1=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and widths for the register-file port controller
// Holds the datapath widths, the controller state encoding and the
// request records used by regfile_port_ctrl and rf_rsp_buf.
package regfile_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        RD_CAP = 1'b1
    } state_t;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } rd_req_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wr_req_t;

endpackage

// File: rtl/rf_rsp_buf.sv
// rtl/rf_rsp_buf.sv - one-entry read-response buffer with valid/ready output
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   load                    capture load_data1/2 this edge (read data arriving)
//   load_data1, load_data2  operand values to capture
//   rsp_ready               downstream consumer ready
//   rsp_valid, rsp_data1/2  buffered response
//   buf_free                entry is empty or draining this cycle
module rf_rsp_buf
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] load_data1,
    input  logic [XLEN-1:0] load_data2,
    input  logic            rsp_ready,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data1,
    output logic [XLEN-1:0] rsp_data2,
    output logic            buf_free
);

    assign buf_free = !rsp_valid || rsp_ready;

    // A load in the same cycle as a drain keeps the entry valid with the new
    // data; without a load, data is left untouched so it holds under stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data1 <= '0;
            rsp_data2 <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_data1 <= load_data1;
            rsp_data2 <= load_data2;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_port_ctrl.sv
// rtl/regfile_port_ctrl.sv - arbitrates write and read requests onto the single register-file port
// Optional feature macro: RF_ZERO_REG_EN (register 0 hardwired to zero).
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   wr_valid/wr_ready, wr_rd, wr_data           writeback write channel
//   rd_valid/rd_ready, rd_rs1, rd_rs2           decode operand-read channel
//   rsp_valid/rsp_ready, rsp_data1, rsp_data2   operand response channel
//   rf_enable, rf_rw, rf_reset    register-file control (rf_rw=1 is a write)
//   rf_rs1, rf_rs2, rf_rd, rf_din register-file addresses and write data
//   rf_out1, rf_out2              register-file registered read data
module regfile_port_ctrl
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [REG_AW-1:0] wr_rd,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [REG_AW-1:0] rd_rs1,
    input  logic [REG_AW-1:0] rd_rs2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data1,
    output logic [XLEN-1:0]   rsp_data2,
    output logic              rf_enable,
    output logic              rf_rw,
    output logic              rf_reset,
    output logic [REG_AW-1:0] rf_rs1,
    output logic [REG_AW-1:0] rf_rs2,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_din,
    input  logic [XLEN-1:0]   rf_out1,
    input  logic [XLEN-1:0]   rf_out2
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  starve_cnt;
    logic              force_rd;
    logic              buf_free;
    logic              wr_grant;
    logic              rd_grant;
    logic              rd_lost_to_wr;
    logic              capture;
    logic [XLEN-1:0]   cap_data1;
    logic [XLEN-1:0]   cap_data2;
    wr_req_t           wr_req;
    rd_req_t           rd_req;

    assign wr_req = '{rd: wr_rd, data: wr_data};
    assign rd_req = '{rs1: rd_rs1, rs2: rd_rs2};

    assign force_rd = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Grants are mutually exclusive: a read needs either no write pending or
    // force_rd, and force_rd suppresses the write grant.
    assign wr_grant = wr_valid && !reset && !force_rd;
    assign rd_grant = rd_valid && !reset && (state == IDLE) && buf_free
                      && (!wr_valid || force_rd);

    // The read would have gone this cycle if not for the write.
    assign rd_lost_to_wr = rd_valid && !reset && (state == IDLE) && buf_free
                           && wr_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        rd_ready   = 1'b0;
        rf_enable  = 1'b0;
        rf_rw      = 1'b0;
        rf_reset   = 1'b0;
        rf_rs1     = '0;
        rf_rs2     = '0;
        rf_rd      = '0;
        rf_din     = '0;

        if (reset) begin
            // Register file clears on the same edge the controller resets.
            rf_enable = 1'b1;
            rf_reset  = 1'b1;
        end else if (wr_grant) begin
            wr_ready = 1'b1;
`ifdef RF_ZERO_REG_EN
            // Writes to x0 are consumed but never reach the array.
            if (wr_req.rd != '0) begin
                rf_enable = 1'b1;
                rf_rw     = 1'b1;
                rf_rd     = wr_req.rd;
                rf_din    = wr_req.data;
            end
`else
            rf_enable = 1'b1;
            rf_rw     = 1'b1;
            rf_rd     = wr_req.rd;
            rf_din    = wr_req.data;
`endif
        end else if (rd_grant) begin
            rd_ready  = 1'b1;
            rf_enable = 1'b1;
            rf_rs1    = rd_req.rs1;
            rf_rs2    = rd_req.rs2;
        end

        case (state)
            IDLE:    if (rd_grant) state_next = RD_CAP;
            RD_CAP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || rd_grant || !rd_valid) begin
            starve_cnt <= '0;
        end else if (rd_lost_to_wr && !force_rd) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Registered read data is valid during RD_CAP; reset in the buffer wins
    // over this, discarding an in-flight read.
    assign capture = (state == RD_CAP);

`ifdef RF_ZERO_REG_EN
    logic rs1_zero_q;
    logic rs2_zero_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_zero_q <= 1'b0;
            rs2_zero_q <= 1'b0;
        end else if (rd_grant) begin
            rs1_zero_q <= (rd_req.rs1 == '0);
            rs2_zero_q <= (rd_req.rs2 == '0);
        end
    end

    assign cap_data1 = rs1_zero_q ? '0 : rf_out1;
    assign cap_data2 = rs2_zero_q ? '0 : rf_out2;
`else
    assign cap_data1 = rf_out1;
    assign cap_data2 = rf_out2;
`endif

    rf_rsp_buf u_rsp_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (capture),
        .load_data1 (cap_data1),
        .load_data2 (cap_data2),
        .rsp_ready  (rsp_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data1  (rsp_data1),
        .rsp_data2  (rsp_data2),
        .buf_free   (buf_free)
    );

endmodule
